// File: rtl/flappy_bus_pkg.sv
// Shared types for the core-bus to SCR1 memory bridge: SCR1 memory-interface
// encodings, bridge FSM states and the store byte-mask decoder.
package flappy_bus_pkg;

  // SCR1 memory-interface encodings (same values as scr1_memif.svh)
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRAIN = 2'b01,
    ERR   = 2'b10
  } bridge_state_e;

  localparam int RSP_W = 33;

  typedef struct packed {
    logic                 legal;
    type_scr1_mem_width_e width;
    logic [1:0]           offset;
  } wmask_dec_t;

  // Only naturally aligned byte, halfword and word masks map onto an SCR1 access.
  function automatic wmask_dec_t wmask_decode(input logic [3:0] wmask);
    wmask_dec_t d;
    d.legal  = 1'b1;
    d.width  = SCR1_MEM_WIDTH_WORD;
    d.offset = 2'b00;
    case (wmask)
      4'b1111: d.width = SCR1_MEM_WIDTH_WORD;
      4'b0011: d.width = SCR1_MEM_WIDTH_HWORD;
      4'b1100: begin
        d.width  = SCR1_MEM_WIDTH_HWORD;
        d.offset = 2'b10;
      end
      4'b0001: d.width = SCR1_MEM_WIDTH_BYTE;
      4'b0010: begin
        d.width  = SCR1_MEM_WIDTH_BYTE;
        d.offset = 2'b01;
      end
      4'b0100: begin
        d.width  = SCR1_MEM_WIDTH_BYTE;
        d.offset = 2'b10;
      end
      4'b1000: begin
        d.width  = SCR1_MEM_WIDTH_BYTE;
        d.offset = 2'b11;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/flappy_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; the head
// entry is read straight from the storage registers.
module flappy_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot in the same cycle, so push on full is fine then.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: rtl/flappy_bus2scr1_bridge.sv
// Core valid/ready cmd/rsp bus to SCR1 req/ack/resp memory bridge with
// outstanding-request tracking and a response FIFO sized against credit.
module flappy_bus2scr1_bridge
  import flappy_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2,
  parameter int RSP_DEPTH = 2,
  parameter bit WRITE_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_address,
  input  logic                 cmd_write,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_wmask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_error,
  output logic                 mem_req_o,
  output type_scr1_mem_cmd_e   mem_cmd_o,
  output type_scr1_mem_width_e mem_width_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_req_ack_i,
  input  logic [31:0]          mem_rdata_i,
  input  type_scr1_mem_resp_e  mem_resp_i
);

  localparam int OW = $clog2(MAX_OUTST+1);
  localparam int CW = $clog2(RSP_DEPTH+1);
  localparam int SW = ((OW > CW) ? OW : CW) + 1;

  bridge_state_e    state;
  logic [OW-1:0]    outst_cnt;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             is_write;
  logic             legal;
  logic             credit;
  logic             err_pend;
  logic             hs;
  logic             mem_rsp;
  logic             push;
  logic             pop;
  logic [RSP_W-1:0] push_data;
  logic [RSP_W-1:0] head;
  wmask_dec_t       dec;

  assign is_write = WRITE_EN && cmd_write;
  assign dec      = wmask_decode(cmd_wmask);
  assign legal    = ~is_write | dec.legal;
  // Every acked request and every buffered response holds a FIFO slot.
  assign credit   = ((SW'(outst_cnt) + SW'(fifo_count)) < SW'(RSP_DEPTH))
                    && (outst_cnt < OW'(MAX_OUTST));
  assign err_pend = (state != IDLE);

  assign mem_req_o   = rst_n & cmd_valid & credit & legal & ~err_pend;
  assign mem_cmd_o   = is_write ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
  assign mem_width_o = is_write ? dec.width : SCR1_MEM_WIDTH_WORD;
  assign mem_addr_o  = {cmd_address[ADDR_W-1:2], (is_write ? dec.offset : 2'b00)};
  assign mem_wdata_o = cmd_wdata;

  assign hs        = mem_req_o & mem_req_ack_i;
  assign cmd_ready = hs | (state == ERR);

  assign mem_rsp   = (mem_resp_i != SCR1_MEM_RESP_NOTRDY) && (outst_cnt != '0);
  assign push      = mem_rsp | (state == ERR);
  assign push_data = (state == ERR) ? {1'b1, 32'h0}
                                    : {(mem_resp_i == SCR1_MEM_RESP_RDY_ER), mem_rdata_i};
  assign pop       = rsp_valid & rsp_ready;

  // An illegal store waits in DRAIN until everything older has been returned,
  // so its error response lands in the FIFO in program order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      outst_cnt <= '0;
    end else begin
      outst_cnt <= outst_cnt + OW'(hs) - OW'(mem_rsp);
      case (state)
        IDLE:    if (cmd_valid && !legal) state <= DRAIN;
        DRAIN:   if (outst_cnt == '0 && !fifo_full) state <= ERR;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  flappy_sync_fifo #(
    .WIDTH(RSP_W),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_error = head[32];
  assign rsp_rdata = head[31:0];

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(mem_resp_i != SCR1_MEM_RESP_NOTRDY && outst_cnt == '0));
    end
  end

endmodule

// File: tb/tb_flappy_bus2scr1_bridge.sv
// Self-checking bench: decode table, directed multi-cycle sequences and a
// randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_flappy_bus2scr1_bridge;
  import flappy_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_error;
  logic [31:0]          cmd_address, cmd_wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]           cmd_wmask;
  logic                 mem_req, mem_ack;
  type_scr1_mem_cmd_e   mem_cmd;
  type_scr1_mem_width_e mem_width;
  type_scr1_mem_resp_e  mem_resp;

  logic                 b_cmd_valid, b_cmd_ready, b_cmd_write, b_rsp_valid, b_rsp_ready, b_rsp_error;
  logic [31:0]          b_cmd_address, b_cmd_wdata, b_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]           b_cmd_wmask;
  logic                 b_mem_req, b_mem_ack;
  type_scr1_mem_cmd_e   b_mem_cmd;
  type_scr1_mem_width_e b_mem_width;
  type_scr1_mem_resp_e  b_mem_resp;

  flappy_bus2scr1_bridge #(.ADDR_W(32), .MAX_OUTST(2), .RSP_DEPTH(2), .WRITE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_address(cmd_address),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_req_o(mem_req), .mem_cmd_o(mem_cmd), .mem_width_o(mem_width), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_req_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
  );

  // Read-only ibus flavour with a deeper FIFO, used for the reset-in-flight case.
  flappy_bus2scr1_bridge #(.ADDR_W(32), .MAX_OUTST(2), .RSP_DEPTH(3), .WRITE_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_address(b_cmd_address),
    .cmd_write(b_cmd_write), .cmd_wdata(b_cmd_wdata), .cmd_wmask(b_cmd_wmask),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error),
    .mem_req_o(b_mem_req), .mem_cmd_o(b_mem_cmd), .mem_width_o(b_mem_width), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_req_ack_i(b_mem_ack), .mem_rdata_i(b_mem_rdata), .mem_resp_i(b_mem_resp)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference mapping from the store-mask rules, computed by counting lanes.
  function automatic void ref_map(input logic wr, input logic [3:0] m, input logic [31:0] a,
                                  output logic legal, output logic [1:0] width,
                                  output logic [31:0] addr);
    int n;
    int lo;
    n  = $countones(m);
    lo = 0;
    for (int k = 3; k >= 0; k--) if (m[k]) lo = k;
    if (!wr) begin
      legal = 1'b1;
      width = 2'd2;
      addr  = {a[31:2], 2'b00};
    end else begin
      legal = (n == 1) || (n == 4) || (n == 2 && (lo == 0 || lo == 2) && m[lo+1]);
      width = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
      addr  = {a[31:2], 2'b00} + 32'(lo);
    end
  endfunction

  typedef struct packed {
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic        exp_req;
    logic [1:0]  exp_width;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[12];
  logic [3:0] legal_masks[7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

  task automatic idle_a();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_wdata = '0; cmd_wmask = '0;
    rsp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0; mem_resp = SCR1_MEM_RESP_NOTRDY;
  endtask

  task automatic idle_b();
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_address = '0; b_cmd_wdata = '0; b_cmd_wmask = '0;
    b_rsp_ready = 1'b0; b_mem_ack = 1'b0; b_mem_rdata = '0; b_mem_resp = SCR1_MEM_RESP_NOTRDY;
  endtask

  task automatic rd_a(input logic [31:0] a, input logic ack);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = a; cmd_wmask = 4'h0; mem_ack = ack;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic        legal;
    logic [1:0]  w;
    logic [31:0] a;
    logic [32:0] exp_q[$];
    logic [32:0] e;
    int          pend_cnt;
    int          nreq;
    bit          seen;
    bit          resp_now;
    bit          drop;

    vecs[0]  = '{1'b1, 4'b0100, 32'h0000_0200, 1'b1, 2'd0, 32'h0000_0202};
    vecs[1]  = '{1'b1, 4'b1100, 32'h0000_0200, 1'b1, 2'd1, 32'h0000_0202};
    vecs[2]  = '{1'b1, 4'b1111, 32'h0000_0200, 1'b1, 2'd2, 32'h0000_0200};
    vecs[3]  = '{1'b1, 4'b0011, 32'h0000_1237, 1'b1, 2'd1, 32'h0000_1234};
    vecs[4]  = '{1'b1, 4'b0001, 32'h0000_0403, 1'b1, 2'd0, 32'h0000_0400};
    vecs[5]  = '{1'b1, 4'b1000, 32'h0000_0400, 1'b1, 2'd0, 32'h0000_0403};
    vecs[6]  = '{1'b1, 4'b0010, 32'hFFFF_FFFC, 1'b1, 2'd0, 32'hFFFF_FFFD};
    vecs[7]  = '{1'b0, 4'b0101, 32'h0000_010E, 1'b1, 2'd2, 32'h0000_010C};
    vecs[8]  = '{1'b1, 4'b0000, 32'h0000_0800, 1'b0, 2'd0, 32'h0};
    vecs[9]  = '{1'b1, 4'b0101, 32'h0000_0800, 1'b0, 2'd0, 32'h0};
    vecs[10] = '{1'b1, 4'b0110, 32'h0000_0800, 1'b0, 2'd0, 32'h0};
    vecs[11] = '{1'b1, 4'b1110, 32'h0000_0800, 1'b0, 2'd0, 32'h0};

    idle_a();
    idle_b();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_error", rsp_error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // test 1: single read, response two cycles after ack
    @(negedge clk); rd_a(32'h100, 1'b1);
    #1;
    chk("t1_req", mem_req, 1'b1);
    chk("t1_cmd_ready", cmd_ready, 1'b1);
    chk("t1_width", mem_width, SCR1_MEM_WIDTH_WORD);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_cmd", mem_cmd, SCR1_MEM_CMD_RD);
    @(negedge clk); idle_a();
    @(negedge clk); mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hDEADBEEF;
    #1 chk("t1_rsp_not_yet", rsp_valid, 1'b0);
    @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY; rsp_ready = 1'b1;
    #1;
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t1_error", rsp_error, 1'b0);
    @(negedge clk); rsp_ready = 1'b0;
    #1 chk("t1_empty", rsp_valid, 1'b0);

    // test 2 plus decode table: stores, reads and illegal masks
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle_a();
      cmd_valid = 1'b1; cmd_write = vecs[i].wr; cmd_wmask = vecs[i].mask;
      cmd_address = vecs[i].addr; cmd_wdata = 32'h11223344;
      #1;
      chk($sformatf("vec%0d_req", i), mem_req, vecs[i].exp_req);
      if (vecs[i].exp_req) begin
        chk($sformatf("vec%0d_width", i), mem_width, vecs[i].exp_width);
        chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
        chk($sformatf("vec%0d_cmd", i), mem_cmd, vecs[i].wr);
        chk($sformatf("vec%0d_wdata", i), mem_wdata, 32'h11223344);
        cmd_valid = 1'b0;
      end else begin
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
          @(negedge clk); #1;
          if (mem_req) chk($sformatf("vec%0d_no_req", i), mem_req, 1'b0);
          seen = cmd_ready;
        end
        chk($sformatf("vec%0d_err_accept", i), seen, 1'b1);
        @(negedge clk); cmd_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d_err_valid", i), rsp_valid, 1'b1);
        chk($sformatf("vec%0d_err_flag", i), rsp_error, 1'b1);
        chk($sformatf("vec%0d_err_rdata", i), rsp_rdata, 32'h0);
        @(negedge clk); rsp_ready = 1'b0;
        #1 chk($sformatf("vec%0d_err_empty", i), rsp_valid, 1'b0);
      end
    end

    // test 3: third read stalls on credit until the core pops
    @(negedge clk); idle_a(); rd_a(32'h1000, 1'b1);
    #1 chk("t3_req_a", mem_req, 1'b1);
    @(negedge clk); rd_a(32'h1004, 1'b1);
    #1 chk("t3_req_b", mem_req, 1'b1);
    @(negedge clk); rd_a(32'h1008, 1'b1); mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hA0;
    #1 chk("t3_stall0", mem_req, 1'b0);
    @(negedge clk); mem_rdata = 32'hB1;
    #1 chk("t3_stall1", mem_req, 1'b0);
    @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY;
    #1 chk("t3_stall2", mem_req, 1'b0);
    chk("t3_head_a", rsp_rdata, 32'hA0);
    @(negedge clk); rsp_ready = 1'b1;
    #1 chk("t3_stall_pop", mem_req, 1'b0);
    @(negedge clk); rsp_ready = 1'b0;
    #1 chk("t3_req_c", mem_req, 1'b1);
    chk("t3_addr_c", mem_addr, 32'h1008);
    @(negedge clk); cmd_valid = 1'b0; mem_ack = 1'b0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hC2;
    @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY; rsp_ready = 1'b1;
    #1 chk("t3_rsp_b", rsp_rdata, 32'hB1);
    @(negedge clk);
    #1 chk("t3_rsp_c", rsp_rdata, 32'hC2);
    @(negedge clk); rsp_ready = 1'b0;
    #1 chk("t3_empty", rsp_valid, 1'b0);

    // test 4: illegal store behind an outstanding legal store
    nreq = 0;
    @(negedge clk); idle_a();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 32'h300; cmd_wmask = 4'hF;
    cmd_wdata = 32'hCAFEF00D; mem_ack = 1'b1;
    #1 chk("t4_req", mem_req, 1'b1);
    nreq += int'(mem_req & mem_ack);
    @(negedge clk); cmd_address = 32'h304; cmd_wmask = 4'b0101;
    #1 chk("t4_held", mem_req, 1'b0);
    chk("t4_not_ready0", cmd_ready, 1'b0);
    nreq += int'(mem_req & mem_ack);
    @(negedge clk); mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h0;
    #1 chk("t4_not_ready1", cmd_ready, 1'b0);
    nreq += int'(mem_req & mem_ack);
    @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY;
    #1 chk("t4_not_ready2", cmd_ready, 1'b0);
    nreq += int'(mem_req & mem_ack);
    @(negedge clk);
    #1 chk("t4_err_ready", cmd_ready, 1'b1);
    nreq += int'(mem_req & mem_ack);
    chk("t4_scr1_reqs", nreq, 1);
    @(negedge clk); cmd_valid = 1'b0; mem_ack = 1'b0; rsp_ready = 1'b1;
    #1 chk("t4_rsp0_err", rsp_error, 1'b0);
    chk("t4_rsp0_valid", rsp_valid, 1'b1);
    @(negedge clk);
    #1 chk("t4_rsp1_err", rsp_error, 1'b1);
    chk("t4_rsp1_rdata", rsp_rdata, 32'h0);
    @(negedge clk); rsp_ready = 1'b0;
    #1 chk("t4_empty", rsp_valid, 1'b0);

    // test 5: RDY_ER on a read, then full credit is available again
    @(negedge clk); idle_a(); rd_a(32'h500, 1'b1);
    #1 chk("t5_req", mem_req, 1'b1);
    @(negedge clk); idle_a(); mem_resp = SCR1_MEM_RESP_RDY_ER; mem_rdata = 32'hBADBAD00;
    @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY; rsp_ready = 1'b1;
    #1 chk("t5_err", rsp_error, 1'b1);
    chk("t5_rdata", rsp_rdata, 32'hBADBAD00);
    @(negedge clk); rsp_ready = 1'b0; rd_a(32'h504, 1'b1);
    #1 chk("t5_req1", mem_req, 1'b1);
    @(negedge clk); rd_a(32'h508, 1'b1);
    #1 chk("t5_req2", mem_req, 1'b1);
    @(negedge clk); idle_a(); mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h51;
    @(negedge clk); mem_rdata = 32'h52;
    @(negedge clk); mem_resp = SCR1_MEM_RESP_NOTRDY; rsp_ready = 1'b1;
    #1 chk("t5_rsp1", rsp_rdata, 32'h51);
    @(negedge clk);
    #1 chk("t5_rsp2", rsp_rdata, 32'h52);
    chk("t5_rsp2_err", rsp_error, 1'b0);
    @(negedge clk); rsp_ready = 1'b0;

    // test 6: read-only bridge, reset with two outstanding and one buffered
    @(negedge clk); idle_b();
    b_cmd_valid = 1'b1; b_cmd_write = 1'b1; b_cmd_wmask = 4'b0101; b_cmd_address = 32'h60F; b_mem_ack = 1'b1;
    #1 chk("t6_ro_req", b_mem_req, 1'b1);
    chk("t6_ro_cmd", b_mem_cmd, SCR1_MEM_CMD_RD);
    chk("t6_ro_width", b_mem_width, SCR1_MEM_WIDTH_WORD);
    chk("t6_ro_addr", b_mem_addr, 32'h60C);
    @(negedge clk); b_cmd_write = 1'b0; b_cmd_address = 32'h610;
    #1 chk("t6_req_b", b_mem_req, 1'b1);
    @(negedge clk); b_cmd_address = 32'h614; b_mem_resp = SCR1_MEM_RESP_RDY_OK; b_mem_rdata = 32'h1111;
    #1 chk("t6_stall", b_mem_req, 1'b0);
    @(negedge clk); b_mem_resp = SCR1_MEM_RESP_NOTRDY;
    #1 chk("t6_req_c", b_mem_req, 1'b1);
    chk("t6_buffered", b_rsp_valid, 1'b1);
    @(negedge clk); idle_b(); rst_n = 1'b0;
    #1;
    chk("t6_rst_req", b_mem_req, 1'b0);
    chk("t6_rst_ready", b_cmd_ready, 1'b0);
    chk("t6_rst_rsp_valid", b_rsp_valid, 1'b0);
    chk("t6_rst_rsp_error", b_rsp_error, 1'b0);
    chk("t6_rst_a_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    b_cmd_valid = 1'b1; b_cmd_address = 32'h700; b_mem_ack = 1'b1;
    #1 chk("t6_post_req", b_mem_req, 1'b1);
    @(negedge clk); idle_b(); b_mem_resp = SCR1_MEM_RESP_RDY_OK; b_mem_rdata = 32'h77;
    #1 chk("t6_post_no_stale", b_rsp_valid, 1'b0);
    @(negedge clk); b_mem_resp = SCR1_MEM_RESP_NOTRDY; b_rsp_ready = 1'b1;
    #1 chk("t6_post_rdata", b_rsp_rdata, 32'h77);
    chk("t6_post_valid", b_rsp_valid, 1'b1);
    @(negedge clk); idle_b();
    #1 chk("t6_post_empty", b_rsp_valid, 1'b0);

    // randomized run against the queue model
    idle_a();
    pend_cnt = 0;
    drop = 1'b0;
    for (int cyc = 0; cyc < 3300; cyc++) begin
      @(negedge clk);
      if (drop) cmd_valid = 1'b0;
      drop = 1'b0;
      resp_now = (pend_cnt > 0) && ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      if (resp_now)
        mem_resp = ($urandom_range(0, 7) == 0) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      else
        mem_resp = SCR1_MEM_RESP_NOTRDY;
      mem_ack = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!cmd_valid && cyc < 3000 && $urandom_range(0, 1) == 1) begin
        cmd_write = 1'($urandom_range(0, 1));
        cmd_address = $urandom;
        cmd_wdata = $urandom;
        cmd_wmask = ($urandom_range(0, 9) < 8) ? legal_masks[$urandom_range(0, 6)] : 4'($urandom_range(0, 15));
        cmd_valid = 1'b1;
      end
      #1;
      chk("rnd_rsp_valid", rsp_valid, exp_q.size() != 0);
      if (cmd_valid) ref_map(cmd_write, cmd_wmask, cmd_address, legal, w, a);
      if (mem_req) begin
        chk("rnd_req_legal", legal, 1'b1);
        chk("rnd_width", mem_width, w);
        chk("rnd_addr", mem_addr, a);
        chk("rnd_cmd", mem_cmd, cmd_write);
        chk("rnd_wdata", mem_wdata, cmd_wdata);
        chk("rnd_credit", (pend_cnt < 2) && (pend_cnt + exp_q.size() < 2), 1'b1);
        chk("rnd_cmd_ready", cmd_ready, mem_ack);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_rdata", rsp_rdata, e[31:0]);
          chk("rnd_error", rsp_error, e[32]);
        end
      end
      if (resp_now) begin
        exp_q.push_back({mem_resp == SCR1_MEM_RESP_RDY_ER, mem_rdata});
        pend_cnt--;
      end
      if (cmd_ready) begin
        if (mem_req) begin
          pend_cnt++;
        end else begin
          chk("rnd_err_accept_illegal", legal, 1'b0);
          exp_q.push_back({1'b1, 32'h0});
        end
        drop = 1'b1;
      end
    end
    chk("rnd_drained", exp_q.size() + pend_cnt + int'(cmd_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
